// File: rtl/d_input_debounce.sv
// Synchronises and debounces a raw input into a clean level with rise/fall strobes.
// Optional abort counter output glitch_cnt enabled by `define DEBOUNCE_GLITCH_COUNT_EN.
module d_input_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_raw,
    output logic       d_clean,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy
`ifdef DEBOUNCE_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   d_clean_q, d_clean_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], din_raw};
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_clean_d = d_clean_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        case (state_q)
            STABLE_LO: if (s) begin
                state_d = CHK_HI;
                cnt_d   = CNT_W'(1);
            end
            CHK_HI: if (!s) begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d   = STABLE_HI;
                cnt_d     = '0;
                d_clean_d = 1'b1;
                rise_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            STABLE_HI: if (!s) begin
                state_d = CHK_LO;
                cnt_d   = CNT_W'(1);
            end
            CHK_LO: if (s) begin
                state_d = STABLE_HI;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d   = STABLE_LO;
                cnt_d     = '0;
                d_clean_d = 1'b0;
                fall_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // busy reflects the state being entered so it lines up with d_clean/strobes
        busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= STABLE_LO;
            cnt_q     <= '0;
            d_clean_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_clean_q <= d_clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            busy_q    <= busy_d;
        end
    end

    assign d_clean    = d_clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

`ifdef DEBOUNCE_GLITCH_COUNT_EN
    logic [7:0] glitch_q, glitch_d;
    logic       abort;

    assign abort = ((state_q == CHK_HI) && !s) || ((state_q == CHK_LO) && s);

    always_comb begin
        glitch_d = glitch_q;
        if (abort && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) glitch_q <= '0;
        else     glitch_q <= glitch_d;
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
